// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   // One buffered fetch: the instruction word and the address it came from
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [INSTR_W-1:0] pc;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Circular buffer of fetch entries with flush. The head entry is
//               presented combinationally and stays put until popped.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   output fetch_entry_t             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int c_AW = $clog2(DEPTH);

   fetch_entry_t    r_mem [DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW:0]   r_count;

   // Pointer and occupancy tracking; flush and reset both empty the queue
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (reset_n && !flush && push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;
   assign empty = (r_count == '0);
   assign full  = (r_count == (c_AW+1)'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Fetch stage. Owns the PC, issues reads to a 1-cycle synchronous
//               instruction memory, buffers responses with their PCs and hands
//               them to decode over valid/ready. Redirect flushes everything.
//               Optional same-cycle bypass of an empty queue: FETCHQ_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
   import fetch_pkg::*;
#(
   parameter int         n        = 32,
   parameter int         DEPTH    = 4,
   parameter logic [n-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         reset_n,
   output logic         imem_req,
   output logic [n-1:0] imem_addr,
   input  logic [n-1:0] imem_rdata,
   input  logic         redirect,
   input  logic [n-1:0] redirect_pc,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [n-1:0] out_instr,
   output logic [n-1:0] out_pc
);

   localparam int c_CW = $clog2(DEPTH) + 1;

   logic [n-1:0]   r_pc;
   logic           r_inflight;
   logic [n-1:0]   r_rsp_pc;
   fetch_entry_t   r_last;

   logic [c_CW-1:0] w_count;
   logic [c_CW:0]   w_occ;
   logic            w_empty;
   logic            w_full;
   fetch_entry_t    w_head;
   fetch_entry_t    w_rsp;
   fetch_entry_t    w_out;
   logic            w_issue;
   logic            w_live;
   logic            w_byp;
   logic            w_push;
   logic            w_pop;
   logic            w_unused_bits;

   // Low address bits of a redirect target are dropped (word alignment)
   assign w_unused_bits = ^redirect_pc[1:0];

   // Queue plus in-flight slot must never exceed capacity; a same-cycle pop
   // earns no credit so the issue path stays independent of out_ready
   assign w_occ    = {1'b0, w_count} + {{c_CW{1'b0}}, r_inflight};
   assign w_issue  = reset_n & ~redirect & (w_occ < (c_CW+1)'(DEPTH));
   assign imem_req  = w_issue;
   assign imem_addr = r_pc;

   // A response is live when its request was issued and no redirect kills it
   assign w_live      = r_inflight & ~redirect;
   assign w_rsp.instr = imem_rdata;
   assign w_rsp.pc    = r_rsp_pc;

`ifdef FETCHQ_BYPASS_EN
   assign w_byp = w_live & w_empty;
`else
   assign w_byp = 1'b0;
`endif

   assign out_valid = (~w_empty | w_byp) & ~redirect;
   assign w_out     = ~w_empty ? w_head : (w_byp ? w_rsp : r_last);
   assign out_instr = w_out.instr;
   assign out_pc    = w_out.pc;

   assign w_pop  = ~w_empty & out_valid & out_ready;
   assign w_push = w_live & ~w_full & ~(w_byp & out_ready);

   // PC, in-flight flag and response PC bookkeeping
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pc       <= RESET_PC;
         r_inflight <= 1'b0;
         r_rsp_pc   <= '0;
      end else if (redirect) begin
         r_pc       <= {redirect_pc[n-1:2], 2'b00};
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_pc     <= r_pc + n'(PC_STEP);
            r_rsp_pc <= r_pc;
         end
      end
   end

   // Remember the last presented entry so outputs hold while the queue is empty
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_last.instr <= NOP_INSTR;
         r_last.pc    <= '0;
      end else if (out_valid) begin
         r_last <= w_out;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (redirect),
      .push      (w_push),
      .push_data (w_rsp),
      .pop       (w_pop),
      .head      (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .count     (w_count)
   );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Directed self-checking bench for instr_fetch_queue with a
//               1-cycle memory model returning addr ^ 0xA5A5A5A5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

   localparam logic [31:0] c_K = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   // Synchronous instruction memory model
   always @(posedge clk) imem_rdata <= imem_addr ^ c_K;

   instr_fetch_queue #(
      .n        (32),
      .DEPTH    (4),
      .RESET_PC (32'h100)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc)
   );

   task automatic test_reset();
      reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
      @(negedge clk); #1;
      tests_run++;
      if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req_pre: got %b expected 0", imem_req); end
      @(negedge clk); #1;
      tests_run++;
      if ({imem_req, out_valid} !== 2'b00) begin tests_failed++; $display("FAIL reset_ctl: got req/valid %b expected 00", {imem_req, out_valid}); end
      tests_run++;
      if (out_pc !== 32'h0 || out_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got pc %h instr %h expected 0 0", out_pc, out_instr); end
      @(negedge clk); reset_n = 1'b1; #1;
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin tests_failed++; $display("FAIL reset_first_req: got %b %h expected 1 00000100", imem_req, imem_addr); end
      @(negedge clk); #1;
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin tests_failed++; $display("FAIL reset_second_req: got %b %h expected 1 00000104", imem_req, imem_addr); end
`ifdef FETCHQ_BYPASS_EN
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== (32'h100 ^ c_K)) begin
         tests_failed++; $display("FAIL reset_first_out: got %b %h %h expected 1 00000100 %h", out_valid, out_pc, out_instr, 32'h100 ^ c_K);
      end
`else
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_early_valid: got %b expected 0", out_valid); end
      @(negedge clk); #1;
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin tests_failed++; $display("FAIL reset_third_req: got %b %h expected 1 00000108", imem_req, imem_addr); end
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== (32'h100 ^ c_K)) begin
         tests_failed++; $display("FAIL reset_first_out: got %b %h %h expected 1 00000100 %h", out_valid, out_pc, out_instr, 32'h100 ^ c_K);
      end
`endif
   endtask

   task automatic test_streaming();
      logic [31:0] exp_pc;
      exp_pc = 32'h104;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         tests_run++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== (exp_pc ^ c_K)) begin
            tests_failed++; $display("FAIL stream_%0d: got %b %h %h expected 1 %h %h", i, out_valid, out_pc, out_instr, exp_pc, exp_pc ^ c_K);
         end
         exp_pc = exp_pc + 32'h4;
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] addrs [4];
      int n_req;
      n_req = 0;
      @(negedge clk); out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0; #1;
      tests_run++;
      if (out_valid !== 1'b0 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL bp_redirect_cycle: got valid %b req %b expected 0 0", out_valid, imem_req); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); redirect = 1'b0; #1;
         if (imem_req === 1'b1) begin
            if (n_req < 4) addrs[n_req] = imem_addr;
            n_req++;
         end
      end
      tests_run++;
      if (n_req != 4) begin tests_failed++; $display("FAIL bp_req_count: got %0d expected 4", n_req); end
      for (int i = 0; i < 4; i++) begin
         if (i < n_req) begin
            tests_run++;
            if (addrs[i] !== 32'(4 * i)) begin tests_failed++; $display("FAIL bp_addr_%0d: got %h expected %h", i, addrs[i], 32'(4 * i)); end
         end
      end
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== c_K) begin
         tests_failed++; $display("FAIL bp_hold: got %b %h %h expected 1 00000000 %h", out_valid, out_pc, out_instr, c_K);
      end
      @(negedge clk); out_ready = 1'b1; #1;
      tests_run++;
      if (imem_req !== 1'b0 || out_pc !== 32'h0) begin tests_failed++; $display("FAIL bp_release0: got req %b pc %h expected 0 00000000", imem_req, out_pc); end
      for (int j = 1; j < 4; j++) begin
         @(negedge clk); #1;
         tests_run++;
         if (out_valid !== 1'b1 || out_pc !== 32'(4 * j) || out_instr !== (32'(4 * j) ^ c_K)) begin
            tests_failed++; $display("FAIL bp_pop_%0d: got %b %h %h expected 1 %h", j, out_valid, out_pc, out_instr, 32'(4 * j));
         end
         if (j == 1) begin
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin tests_failed++; $display("FAIL bp_resume: got %b %h expected 1 00000010", imem_req, imem_addr); end
         end
      end
   endtask

   task automatic test_redirect();
      bit seen;
      seen = 1'b0;
      @(negedge clk); out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); redirect = 1'b0; #1;
      end
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h4C) begin tests_failed++; $display("FAIL redir_setup: got %b %h expected 1 0000004c", imem_req, imem_addr); end
      @(negedge clk); redirect = 1'b1; redirect_pc = 32'h2003; out_ready = 1'b1; #1;
      tests_run++;
      if (out_valid !== 1'b0 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL redir_cycle: got valid %b req %b expected 0 0", out_valid, imem_req); end
      @(negedge clk); redirect = 1'b0; #1;
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h2000 || out_valid !== 1'b0) begin
         tests_failed++; $display("FAIL redir_next_req: got req %b addr %h valid %b expected 1 00002000 0", imem_req, imem_addr, out_valid);
      end
      for (int k = 0; k < 4 && !seen; k++) begin
         @(negedge clk); #1;
         if (out_valid === 1'b1) begin
            seen = 1'b1;
            tests_run++;
            if (out_pc !== 32'h2000 || out_instr !== (32'h2000 ^ c_K)) begin
               tests_failed++; $display("FAIL redir_first_out: got %h %h expected 00002000 %h", out_pc, out_instr, 32'h2000 ^ c_K);
            end
         end
      end
      if (!seen) begin tests_run++; tests_failed++; $display("FAIL redir_timeout: got no out_valid expected one within 4 cycles"); end
   endtask

   task automatic test_push_pop();
      @(negedge clk); out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); redirect = 1'b0;
      end
      @(negedge clk); out_ready = 1'b1; #1;
      tests_run++;
      if (imem_req !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h300) begin
         tests_failed++; $display("FAIL pp_start: got req %b valid %b pc %h expected 0 1 00000300", imem_req, out_valid, out_pc);
      end
      for (int j = 1; j < 5; j++) begin
         @(negedge clk); #1;
         tests_run++;
         if (out_valid !== 1'b1 || out_pc !== (32'h300 + 32'(4 * j)) || out_instr !== ((32'h300 + 32'(4 * j)) ^ c_K)) begin
            tests_failed++; $display("FAIL pp_order_%0d: got %b %h %h expected 1 %h", j, out_valid, out_pc, out_instr, 32'h300 + 32'(4 * j));
         end
         if (j == 1) begin
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h310) begin tests_failed++; $display("FAIL pp_issue: got %b %h expected 1 00000310", imem_req, imem_addr); end
         end
      end
   endtask

   task automatic test_reset_redirect();
      @(negedge clk); reset_n = 1'b0; redirect = 1'b1; redirect_pc = 32'h5000; out_ready = 1'b1; #1;
      tests_run++;
      if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL rr_req: got %b expected 0", imem_req); end
      @(negedge clk); reset_n = 1'b1; redirect = 1'b0; #1;
      tests_run++;
      if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         tests_failed++; $display("FAIL rr_after: got valid %b req %b addr %h expected 0 1 00000100", out_valid, imem_req, imem_addr);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_addr;
      exp_addr = 32'hFFFF_FFF8;
      @(negedge clk); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); redirect = 1'b0; #1;
         tests_run++;
         if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
            tests_failed++; $display("FAIL wrap_%0d: got %b %h expected 1 %h", i, imem_req, imem_addr, exp_addr);
         end
         exp_addr = exp_addr + 32'h4;
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_redirect();
      test_push_pop();
      test_reset_redirect();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage between the program-counter register and instruction decode.
- Owns the PC and issues word-aligned reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions, each with its PC, in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirect by flushing buffered and in-flight fetches.

Parameters:
- n, 32, data and address width in bits.
- DEPTH, 4, FIFO entries; power of two, 2 to 16.
- RESET_PC, 0, PC value loaded on reset; must be word aligned.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- imem_req  output  1  read request to instruction memory this cycle.
- imem_addr  output  n  read address; equals the PC.
- imem_rdata  input  n  read data, valid the cycle after imem_req.
- redirect  input  1  branch/jump taken; flush and reload the PC.
- redirect_pc  input  n  new PC; bits [1:0] are ignored and forced to 0.
- out_valid  output  1  out_instr/out_pc hold a valid instruction.
- out_ready  input  1  decode accepts this cycle.
- out_instr  output  n  instruction word.
- out_pc  output  n  address of out_instr.

Behaviour:
- One clock domain. Reset is synchronous and active-low: all state updates only on rising clk, and reset_n=0 at an edge overrides every other input.
- Reset values: pc=RESET_PC, FIFO count=0, inflight=0, imem_req=0, out_valid=0, out_instr=0, out_pc=0.
- Reset asserted mid-operation discards all queued and in-flight data; the first request is issued in the first cycle with reset_n=1.
- Issue rule: imem_req = reset_n & !redirect & (count + inflight < DEPTH). No credit is taken for a same-cycle pop.
- On each issue: imem_addr=pc, pc <= pc+4 (wraps modulo 2^n), inflight <= 1, and the request's PC is latched as rsp_pc.
- Response: in the cycle after an issue, imem_rdata and rsp_pc are written into the FIFO at the clock edge, unless killed by redirect.
- Latency: request in cycle t gives out_valid=1 in cycle t+2 when nothing is ahead in the queue.
- Handshake: a pop occurs when out_valid & out_ready. out_instr/out_pc must stay stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: count is unchanged and the FIFO order is preserved.
- Full: with count=DEPTH, no issue and no overflow are possible, by the issue rule.
- Empty: out_valid=0, and out_instr/out_pc hold their last value.
- Redirect, combinational effects: out_valid forced to 0 in the redirect cycle (no pop counted) and no issue.
- Redirect, at the clock edge: count <= 0, pointers reset, pc <= {redirect_pc[n-1:2],2'b00}, any response arriving in the next cycle is discarded.
- First fetch after a redirect is issued in the cycle following it.
- Redirect on consecutive cycles: the last one wins.
- Redirect together with reset: reset wins.
- FIFO: circular buffer, read/write pointers of log2(DEPTH) bits that wrap naturally, and a separate count of log2(DEPTH)+1 bits.

Optional Feature:
- Macro FETCHQ_BYPASS_EN.
- Defined: when the FIFO is empty and a live (un-killed) response arrives, it drives out_instr/out_pc and out_valid=1 in that same cycle (t+1 latency).
  - If out_ready=1 it is consumed and not written.
  - Otherwise it is written into the FIFO as usual.
- Undefined: all responses pass through the FIFO (t+2 latency). Handshake and redirect rules are identical in both builds.

Decomposition:
- Package fetch_pkg:
  - INSTR_W=32 and PC_STEP=4.
  - NOP_INSTR=32'h0000_0000.
  - typedef fetch_entry_t struct packed {instr, pc}.
- One natural sub-module, fetch_fifo: parameterised DEPTH with push, pop, flush, full, empty and count, storing fetch_entry_t.
- The top level holds the PC, inflight/rsp_pc state, issue logic and the bypass mux.

Test Plan:
- Reset: RESET_PC=0x100, reset_n low for 2 cycles, then high, out_ready=1 -> imem_req=1 with addr 0x100, 0x104, 0x108 on consecutive cycles; first out_valid 2 cycles after the 0x100 request (1 cycle with bypass), with out_pc=0x100.
- Streaming: memory returns instr = addr^0xA5A5A5A5, out_ready=1 for 20 cycles -> one instruction per cycle after warm-up, PCs strictly +4, no gaps, no duplicates.
- Backpressure: out_ready=0 from the start -> exactly DEPTH=4 requests (0x0, 0x4, 0x8, 0xC), then imem_req=0. out_instr holds entry 0x0. On release, 4 pops in order, then issuing resumes at 0x10.
- Redirect: with 3 entries queued and 1 in flight, pulse redirect with redirect_pc=0x2003 -> out_valid=0 that cycle, in-flight response discarded, next request addr=0x2000, next out_pc=0x2000.
- Simultaneous push and pop at count=DEPTH-1 -> count stays 3, order intact. Reset asserted during a redirect cycle -> PC=RESET_PC, queue empty.
- Wrap: redirect_pc=0xFFFFFFF8 -> fetches 0xFFFFFFF8, 0xFFFFFFFC, then 0x00000000.
